// File: rtl/serial_port_demux.sv
// serial_port_demux: frames {start, addr, len, payload[, parity]} on SerIn and
// routes the payload bits combinationally onto the addressed port of P.
module serial_port_demux #(
    parameter int ADDR_W    = 2,
    parameter int LEN_W     = 4,
    parameter int PARITY_EN = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clkEn,
    input  logic                 SerIn,
    output logic [2**ADDR_W-1:0] P,
    output logic                 SerOutValid,
    output logic                 Done,
    output logic                 ParErr,
    output logic [LEN_W-1:0]     Count,
    output logic [6:0]           SSD_Out
);
    localparam int NP = 2**ADDR_W;
    localparam int MW = ADDR_W > LEN_W ? ADDR_W : LEN_W;
    localparam int CW = $clog2(MW + 1);
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, PAR, DONE} state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  count_q, len_d;
    logic [CW-1:0]     bit_q;
    logic              par_q, parerr_q;
    logic [3:0]        nib;

    assign addr_d = ADDR_W'({addr_q, SerIn});
    assign len_d  = LEN_W'({count_q, SerIn});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            count_q  <= '0;
            bit_q    <= '0;
            par_q    <= 1'b0;
            parerr_q <= 1'b0;
        end else if (state_q == DONE) begin
            state_q <= IDLE;
        end else if (clkEn) begin
            case (state_q)
                IDLE: if (!SerIn) begin
                    state_q  <= ADDR;
                    bit_q    <= CW'(ADDR_W - 1);
                    par_q    <= 1'b0;
                    parerr_q <= 1'b0;
                end
                ADDR: begin
                    addr_q <= addr_d;
                    bit_q  <= bit_q - 1'b1;
                    if (bit_q == '0) begin
                        state_q <= LEN;
                        bit_q   <= CW'(LEN_W - 1);
                    end
                end
                LEN: begin
                    count_q <= len_d;
                    bit_q   <= bit_q - 1'b1;
                    if (bit_q == '0) state_q <= (len_d != '0) ? DATA : DONE;
                end
                DATA: begin
                    count_q <= count_q - 1'b1;
                    par_q   <= par_q ^ SerIn;
                    if (count_q == LEN_W'(1)) state_q <= (PARITY_EN != 0) ? PAR : DONE;
                end
                PAR: begin
                    if (par_q ^ SerIn) parerr_q <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Routing is deliberately combinational so payload bits reach the port with zero latency.
    assign P           = (state_q == DATA && SerIn) ? NP'(1) << addr_q : '0;
    assign SerOutValid = state_q == DATA;
    assign Done        = state_q == DONE;
    assign ParErr      = parerr_q;
    assign Count       = count_q;
    assign nib         = 4'(count_q);
    assign SSD_Out     = SEG[nib];
endmodule

// File: tb/tb_serial_port_demux.sv
// tb_serial_port_demux: three configurations (default, parity, 3/5-bit fields)
// driven from a frame table plus random frames, checked against a per-bit frame model.
module tb_serial_port_demux;
    logic       clk = 0, rst = 1, clkEn = 0;
    logic [2:0] sin = '1;
    logic [3:0] p0, p1;
    logic [7:0] p2;
    logic [3:0] c0, c1;
    logic [4:0] c2;
    logic [6:0] g0, g1, g2;
    logic [2:0] v, d, e;
    int         sel = 0;
    int         tests = 0, fails = 0;
    logic       last_perr [3] = '{0, 0, 0};
    logic [6:0] seg_tb [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        int          sel, addr, len;
        logic [31:0] data;
        logic        par;
        int          div;
        logic        perr;
    } frame_t;

    serial_port_demux u0 (.clk(clk), .rst(rst), .clkEn(clkEn), .SerIn(sin[0]), .P(p0),
        .SerOutValid(v[0]), .Done(d[0]), .ParErr(e[0]), .Count(c0), .SSD_Out(g0));
    serial_port_demux #(.PARITY_EN(1)) u1 (.clk(clk), .rst(rst), .clkEn(clkEn), .SerIn(sin[1]), .P(p1),
        .SerOutValid(v[1]), .Done(d[1]), .ParErr(e[1]), .Count(c1), .SSD_Out(g1));
    serial_port_demux #(.ADDR_W(3), .LEN_W(5)) u2 (.clk(clk), .rst(rst), .clkEn(clkEn), .SerIn(sin[2]), .P(p2),
        .SerOutValid(v[2]), .Done(d[2]), .ParErr(e[2]), .Count(c2), .SSD_Out(g2));

    always #5 clk = ~clk;

    wire [7:0] p_m   = sel == 2 ? p2 : sel == 1 ? {4'b0, p1} : {4'b0, p0};
    wire [4:0] cnt_m = sel == 2 ? c2 : sel == 1 ? {1'b0, c1} : {1'b0, c0};
    wire [6:0] ssd_m = sel == 2 ? g2 : sel == 1 ? g1 : g0;
    wire       vld_m = v[sel];
    wire       don_m = d[sel];
    wire       err_m = e[sel];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", nm, sel, $time, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_p"}, p_m, 0);
        chk({nm, "_vld"}, vld_m, 0);
        chk({nm, "_count"}, cnt_m, 0);
        chk({nm, "_ssd"}, ssd_m, 7'b1000000);
    endtask

    // Frame model: the bit at frame position k and what the outputs must show while it is on the wire.
    task automatic run_frame(input frame_t f);
        int   aw, lw, n, j, cnt;
        logic pen, b, is_data;
        aw  = f.sel == 2 ? 3 : 2;
        lw  = f.sel == 2 ? 5 : 4;
        pen = f.sel == 1;
        n   = 1 + aw + lw + f.len + ((pen && f.len > 0) ? 1 : 0);
        sel = f.sel;
        for (int k = 0; k < n; k++) begin
            is_data = k > aw + lw && k <= aw + lw + f.len;
            j = k - aw - lw - 1;
            b = k == 0 ? 1'b0 : k <= aw ? f.addr[aw - k] : k <= aw + lw ? f.len[lw - (k - aw)] :
                is_data ? f.data[f.len - 1 - j] : f.par;
            cnt = is_data ? f.len - j : 0;
            for (int c = 0; c < f.div; c++) begin
                @(negedge clk);
                sin = '1;
                sin[f.sel] = b;
                clkEn = (c == f.div - 1);
                #1;
                chk("route", p_m, (is_data && b) ? (32'd1 << f.addr) : 32'd0);
                chk("valid", vld_m, is_data);
                chk("done_low", don_m, 0);
                chk("parerr_mid", err_m, k == 0 ? last_perr[f.sel] : 1'b0);
                if (k <= aw || k > aw + lw) begin
                    chk("count", cnt_m, cnt);
                    chk("ssd", ssd_m, seg_tb[cnt[3:0]]);
                end
            end
        end
        @(negedge clk);
        sin = '1;
        clkEn = (f.div == 1);
        #1;
        chk("done_pulse", don_m, 1);
        chk_idle("done_cycle");
        chk("parerr_end", err_m, f.perr);
        @(negedge clk);
        #1;
        chk("done_once", don_m, 0);
        chk_idle("after_done");
        chk("parerr_hold", err_m, f.perr);
        last_perr[f.sel] = f.perr;
    endtask

    frame_t      tbl [8];
    frame_t      fr;
    logic [7:0]  seq;
    logic [31:0] mask;

    initial begin
        tbl[0] = '{0, 2, 3,  32'b101,        1'b0, 1, 1'b0};
        tbl[1] = '{0, 1, 0,  32'd0,          1'b0, 1, 1'b0};
        tbl[2] = '{0, 2, 3,  32'b101,        1'b0, 3, 1'b0};
        tbl[3] = '{1, 0, 3,  32'b110,        1'b1, 1, 1'b1};
        tbl[4] = '{1, 0, 3,  32'b110,        1'b0, 1, 1'b0};
        tbl[5] = '{2, 7, 31, 32'h5a3c_96e1,  1'b0, 1, 1'b0};
        tbl[6] = '{0, 3, 15, 32'h0000_4d2b,  1'b0, 2, 1'b0};
        tbl[7] = '{1, 2, 0,  32'd0,          1'b1, 1, 1'b0};

        #2;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk_idle("reset");
            chk("reset_done", don_m, 0);
            chk("reset_parerr", err_m, 0);
        end
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);

        foreach (tbl[i]) run_frame(tbl[i]);

        // Abort a frame with an asynchronous reset while two payload bits remain.
        sel = 0;
        seq = 8'b0010_0111;
        for (int k = 7; k >= 0; k--) begin
            @(negedge clk);
            sin = {2'b11, seq[k]};
            clkEn = 1;
        end
        @(negedge clk);
        sin = 3'b111;
        #1;
        chk("abort_count", cnt_m, 2);
        chk("abort_route", p_m, 8'h02);
        rst = 1;
        #1;
        chk_idle("abort_reset");
        chk("abort_done", don_m, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("abort_no_done", don_m, 0);
        end
        rst = 0;
        last_perr = '{0, 0, 0};
        run_frame(tbl[0]);

        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < 12; r++) begin
                fr.sel  = s;
                fr.addr = $urandom_range(0, s == 2 ? 7 : 3);
                fr.len  = $urandom_range(0, s == 2 ? 31 : 15);
                fr.data = $urandom;
                fr.par  = 1'($urandom_range(0, 1));
                fr.div  = $urandom_range(1, 3);
                mask    = (32'd1 << fr.len) - 1;
                fr.perr = s == 1 && fr.len > 0 && (($countones(fr.data & mask) + int'(fr.par)) % 2 == 1);
                run_frame(fr);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
